// File: rtl/aes256_dec_round_ctrl.sv
// Iterative AES-256 inverse cipher: one round per clock, accept to out_valid in 15 cycles.
// in_ready only in IDLE; result held in DONE until out_ready, so the sink may stall indefinitely.
module aes256_dec_round_ctrl #(
    parameter int NR     = 14,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      ciphertext,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      plaintext,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Inverse affine map followed by field inversion (y^254, which also sends 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] r;
        logic [7:0] p;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        r = 8'h01;
        p = y;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2;
        logic [7:0]   x4;
        logic [7:0]   x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(4*c+r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    fsm_e              fsm_q, fsm_d;
    logic [127:0]      state_q, state_d;
    logic [KIDX_W-1:0] cnt_q, cnt_d;
    logic [127:0]      round_pre;

    // Shared by ROUND and FINAL; only ROUND adds the inverse mix-columns.
    assign round_pre = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_data;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ciphertext ^ rk_data;
                    cnt_d   = KIDX_W'(NR - 1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = inv_mix_columns(round_pre);
                if (cnt_q == KIDX_W'(1)) fsm_d = FINAL;
                else cnt_d = cnt_q - KIDX_W'(1);
            end
            FINAL: begin
                state_d = round_pre;
                cnt_d   = '0;
                fsm_d   = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        rk_idx = '0;
        unique case (fsm_q)
            IDLE:    rk_idx = KIDX_W'(NR);
            ROUND:   rk_idx = cnt_q;
            default: rk_idx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign plaintext = state_q;

endmodule

// File: tb/tb_aes256_dec_round_ctrl.sv
// Directed bench for aes256_dec_round_ctrl: forward-cipher reference, key store modelled as a table.
module tb_aes256_dec_round_ctrl;
    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    logic [127:0] rk_tab [16];
    logic [7:0]   sbox_t [256];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes256_dec_round_ctrl #(.NR(NR), .KIDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .rk_idx(rk_idx), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
    );

    assign rk_data = rk_tab[rk_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_tab[15] = '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[127-8*(4*c+w) -: 8] = t[127-8*(4*((c+w)%4)+w) -: 8];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-8*(4*c)   -: 8];
                    a1 = s[127-8*(4*c+1) -: 8];
                    a2 = s[127-8*(4*c+2) -: 8];
                    a3 = s[127-8*(4*c+3) -: 8];
                    s[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rk_tab[r];
        end
        return s;
    endfunction

    // Called on a falling edge; returns one falling edge after the accept edge.
    task automatic send(input logic [127:0] ct, input bit keep, output int acc);
        int n;
        n = 0;
        ciphertext = ct;
        in_valid   = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 128'(in_ready), 128'(1));
        chk("rk_idle", 128'(rk_idx), 128'(NR));
        acc = cyc;
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(cyc - acc), 128'(15));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, seen;
        logic [127:0] ct2;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ciphertext = '0;
        build_sbox();
        expand_key(KEY);
        ct2 = encrypt(CT1);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_pt", plaintext, 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(NR));
        rst_n = 1'b1;
        @(negedge clk);

        // C.3 vector, key index sequence and single-cycle out_valid
        send(CT1, 1'b0, a1);
        for (int k = 1; k <= 14; k++) begin
            chk("rk_seq", 128'(rk_idx), 128'(14 - k));
            chk("busy_run", 128'(busy), 128'(1));
            @(negedge clk);
        end
        chk("c3_lat", 128'(cyc - a1), 128'(15));
        chk("c3_valid", 128'(out_valid), 128'(1));
        chk("c3_pt", plaintext, PT1);
        chk("c3_rk_done", 128'(rk_idx), 128'(0));
        @(negedge clk);
        chk("c3_valid_drop", 128'(out_valid), 128'(0));
        chk("c3_idle", 128'(in_ready), 128'(1));

        // Backpressure
        out_ready = 1'b0;
        send(CT1, 1'b0, a1);
        wait_out(a1, "bp");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            out_ready = (k == 19);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_pt", plaintext, PT1);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(negedge clk);
        chk("bp_release_rdy", 128'(in_ready), 128'(1));
        chk("bp_release_vld", 128'(out_valid), 128'(0));

        // Input changes while busy are ignored; second block waits for IDLE
        send(CT1, 1'b1, a1);
        ciphertext = '0;
        wait_out(a1, "ign");
        chk("ign_pt", plaintext, PT1);
        send('0, 1'b0, a2);
        chk("ign_gap", 128'(a2 - a1), 128'(16));
        wait_out(a2, "ign2");
        chk("ign2_pt", encrypt(plaintext), 128'(0));
        @(negedge clk);

        // Back-to-back with in_valid held
        send(CT1, 1'b1, a1);
        ciphertext = ct2;
        wait_out(a1, "b2b1");
        chk("b2b1_pt", plaintext, PT1);
        send(ct2, 1'b0, a2);
        chk("b2b_gap", 128'(a2 - a1), 128'(16));
        wait_out(a2, "b2b2");
        chk("b2b2_pt", plaintext, CT1);
        @(negedge clk);

        // Asynchronous reset at round 7
        send(CT1, 1'b0, a1);
        repeat (6) @(negedge clk);
        chk("mid_rk7", 128'(rk_idx), 128'(7));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_pt", plaintext, 128'(0));
        chk("mid_rk_idx", 128'(rk_idx), 128'(NR));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_no_out", 128'(seen), 128'(0));
        send(CT1, 1'b0, a1);
        wait_out(a1, "mid_fresh");
        chk("mid_fresh_pt", plaintext, PT1);
        @(negedge clk);

        // All-zero key schedule, all-zero ciphertext
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        send('0, 1'b0, a1);
        for (int k = 1; k <= 15; k++) begin
            chk("zk_busy", 128'(busy), 128'(1));
            if (k < 15) @(negedge clk);
        end
        chk("zk_valid", 128'(out_valid), 128'(1));
        chk("zk_pt", encrypt(plaintext), 128'(0));
        @(negedge clk);
        chk("zk_busy_exit", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
